// File: rtl/radio_ramp_sequencer_if.sv
// Signal bundle between the stage-2 timing engine (master) and the radio ramp sequencer (slave).
// The PLL status and isolation control ride along so the sequencer has a single bus port.
interface radio_ramp_sequencer_if #(
   parameter int BIT_WIDTH = 2
);
   logic                 isolateM3;
   logic [BIT_WIDTH-1:0] radioEnable;
   logic [BIT_WIDTH-1:0] radioRxEn;
   logic [BIT_WIDTH-1:0] pllSettled;
   logic [BIT_WIDTH-1:0] txEn;
   logic [BIT_WIDTH-1:0] rxEn;
   logic                 rampActive;
   logic                 pllErr;
   logic [2:0]           seqState;

   modport master (
      output isolateM3, radioEnable, radioRxEn, pllSettled,
      input  txEn, rxEn, rampActive, pllErr, seqState
   );

   modport slave (
      input  isolateM3, radioEnable, radioRxEn, pllSettled,
      output txEn, rxEn, rampActive, pllErr, seqState
   );
endinterface

// File: rtl/radio_ramp_sequencer.sv
// Radio power-up sequencer: ramp up, wait for PLL lock with timeout, active, ramp down.
// Outputs are registered from the next state; the isolation clamp is applied after the flops.
module radio_ramp_sequencer #(
   parameter int BIT_WIDTH   = 2,
   parameter int RAMP_CYCLES = 4,
   parameter int PLL_TIMEOUT = 16,
   parameter int DOWN_CYCLES = 2
) (
   input logic                   ck,
   input logic                   arst,
   radio_ramp_sequencer_if.slave bus
);

   localparam int MAX_RU = (RAMP_CYCLES > PLL_TIMEOUT) ? RAMP_CYCLES : PLL_TIMEOUT;
   localparam int MAX_CY = (MAX_RU > DOWN_CYCLES) ? MAX_RU : DOWN_CYCLES;
   localparam int CNT_W  = $clog2(MAX_CY + 1);

   localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(DOWN_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      WAIT_PLL  = 3'd2,
      ACTIVE    = 3'd3,
      RAMP_DOWN = 3'd4,
      ERROR     = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0] ch_mask_q, ch_mask_d;
   logic [BIT_WIDTH-1:0] rx_mask_q, rx_mask_d;
   logic [BIT_WIDTH-1:0] tx_q, tx_d;
   logic [BIT_WIDTH-1:0] rx_q, rx_d;
   logic                 ramp_q, ramp_d;
   logic                 err_q, err_d;

   logic req;
   logic pll_ok;

   assign req    = |bus.radioEnable;
   assign pll_ok = (bus.pllSettled & ch_mask_q) == ch_mask_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      cnt_d     = cnt_q;
      ch_mask_d = ch_mask_q;
      rx_mask_d = rx_mask_q;

      // A falling request always wins over timeout, PLL loss and ramp completion.
      case (state_q)
         IDLE: begin
            if (req) begin
               ch_mask_d = bus.radioEnable;
               rx_mask_d = bus.radioRxEn;
               cnt_d     = '0;
               state_d   = RAMP_UP;
            end
         end
         RAMP_UP: begin
            if (!req) begin
               state_d = RAMP_DOWN;
               cnt_d   = '0;
            end else if (cnt_q == RAMP_LAST) begin
               state_d = WAIT_PLL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_PLL: begin
            if (!req) begin
               state_d = RAMP_DOWN;
               cnt_d   = '0;
            end else if (pll_ok) begin
               state_d = ACTIVE;
               cnt_d   = '0;
            end else if (cnt_q == PLL_LAST) begin
               state_d = ERROR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (!req) begin
               state_d = RAMP_DOWN;
               cnt_d   = '0;
            end else if (!pll_ok) begin
               state_d = ERROR;
               cnt_d   = '0;
            end
         end
         ERROR: begin
            if (!req) begin
               state_d = RAMP_DOWN;
               cnt_d   = '0;
            end
         end
         RAMP_DOWN: begin
            if (cnt_q == DOWN_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      tx_d = '0;
      rx_d = '0;
      if (state_d == ACTIVE) begin
         tx_d = ch_mask_d & ~rx_mask_d;
         rx_d = ch_mask_d & rx_mask_d;
      end
      ramp_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
      err_d  = (state_d == ERROR);
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ch_mask_q <= '0;
         rx_mask_q <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         ramp_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ch_mask_q <= ch_mask_d;
         rx_mask_q <= rx_mask_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         ramp_q    <= ramp_d;
         err_q     <= err_d;
      end
   end

   assign bus.txEn       = tx_q & {BIT_WIDTH{~bus.isolateM3}};
   assign bus.rxEn       = rx_q & {BIT_WIDTH{~bus.isolateM3}};
   assign bus.rampActive = ramp_q & ~bus.isolateM3;
   assign bus.pllErr     = err_q & ~bus.isolateM3;
   assign bus.seqState   = state_q;

endmodule

// File: tb/tb_radio_ramp_sequencer.sv
// Self-checking bench for radio_ramp_sequencer: directed scenarios plus randomized episodes
// compared against a phase/elapsed-time reference model.
module tb_radio_ramp_sequencer;

   localparam int W    = 2;
   localparam int RAMP = 4;
   localparam int TO   = 16;
   localparam int DOWN = 2;

   localparam int P_IDLE = 0, P_UP = 1, P_WAIT = 2, P_ACT = 3, P_DOWN = 4, P_ERR = 5;

   logic ck;
   logic arst;
   int   checks = 0;
   int   errors = 0;

   radio_ramp_sequencer_if #(.BIT_WIDTH(W)) bus ();

   radio_ramp_sequencer #(
      .BIT_WIDTH  (W),
      .RAMP_CYCLES(RAMP),
      .PLL_TIMEOUT(TO),
      .DOWN_CYCLES(DOWN)
   ) dut (
      .ck  (ck),
      .arst(arst),
      .bus (bus)
   );

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Reference model: current phase, cycles spent in it, and the masks captured at request time.
   int         ph;
   int         age;
   logic [W-1:0] m_ch;
   logic [W-1:0] m_rx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph   = P_IDLE;
      age  = 0;
      m_ch = '0;
      m_rx = '0;
   endtask

   task automatic model_step();
      int  nph;
      logic req;
      logic locked;
      nph    = ph;
      req    = |bus.radioEnable;
      locked = (bus.pllSettled & m_ch) == m_ch;
      case (ph)
         P_IDLE: if (req) begin
            m_ch = bus.radioEnable;
            m_rx = bus.radioRxEn;
            nph  = P_UP;
         end
         P_UP:   if (!req) nph = P_DOWN; else if (age == RAMP - 1) nph = P_WAIT;
         P_WAIT: if (!req) nph = P_DOWN; else if (locked) nph = P_ACT; else if (age == TO - 1) nph = P_ERR;
         P_ACT:  if (!req) nph = P_DOWN; else if (!locked) nph = P_ERR;
         P_ERR:  if (!req) nph = P_DOWN;
         P_DOWN: if (age == DOWN - 1) nph = P_IDLE;
         default: nph = P_IDLE;
      endcase
      age = (nph != ph) ? 0 : age + 1;
      ph  = nph;
   endtask

   task automatic compare_all();
      logic [W-1:0] e_tx, e_rx;
      logic         e_ramp, e_err;
      e_tx   = (ph == P_ACT) ? (m_ch & ~m_rx) : '0;
      e_rx   = (ph == P_ACT) ? (m_ch & m_rx) : '0;
      e_ramp = (ph == P_UP) || (ph == P_DOWN);
      e_err  = (ph == P_ERR);
      if (bus.isolateM3) begin
         e_tx   = '0;
         e_rx   = '0;
         e_ramp = 1'b0;
         e_err  = 1'b0;
      end
      check("seqState",   32'(bus.seqState),   32'(ph));
      check("txEn",       32'(bus.txEn),       32'(e_tx));
      check("rxEn",       32'(bus.rxEn),       32'(e_rx));
      check("rampActive", 32'(bus.rampActive), 32'(e_ramp));
      check("pllErr",     32'(bus.pllErr),     32'(e_err));
   endtask

   task automatic cycle();
      @(posedge ck);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drive(input logic [W-1:0] en, input logic [W-1:0] rx, input logic [W-1:0] pll);
      bus.radioEnable = en;
      bus.radioRxEn   = rx;
      bus.pllSettled  = pll;
   endtask

   // Pulses arst well away from any clock edge; called right after cycle().
   task automatic async_reset_pulse();
      #2;
      arst = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1;
      arst = 1'b0;
   endtask

   initial begin
      int ramp_n;
      logic [W-1:0] en, rx, pll, target;
      int hold, gap, settle_at, mode;

      arst          = 1'b1;
      bus.isolateM3 = 1'b0;
      drive('0, '0, '0);
      model_reset();
      #12;
      check("reset_seq",  32'(bus.seqState),   32'd0);
      check("reset_tx",   32'(bus.txEn),       32'd0);
      check("reset_rx",   32'(bus.rxEn),       32'd0);
      check("reset_ramp", 32'(bus.rampActive), 32'd0);
      check("reset_err",  32'(bus.pllErr),     32'd0);
      arst = 1'b0;
      run(2);

      // Normal TX on channel 0.
      drive(2'b01, 2'b00, 2'b01);
      ramp_n = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         ramp_n += int'(bus.rampActive);
      end
      check("tx_before_active", 32'(bus.txEn), 32'd0);
      check("seq_wait_pll", 32'(bus.seqState), 32'd2);
      cycle();
      check("tx_at_6", 32'(bus.txEn), 32'h1);
      check("rx_in_tx_mode", 32'(bus.rxEn), 32'd0);
      check("ramp_up_cycles", 32'(ramp_n), 32'd4);
      drive('0, '0, 2'b01);
      run(3);
      check("normal_back_idle", 32'(bus.seqState), 32'd0);

      // PLL timeout, then ramp-down.
      drive(2'b11, 2'b00, 2'b01);
      run(20);
      check("timeout_still_wait", 32'(bus.seqState), 32'd2);
      check("timeout_no_err_yet", 32'(bus.pllErr), 32'd0);
      run(1);
      check("timeout_err", 32'(bus.pllErr), 32'd1);
      check("timeout_seq", 32'(bus.seqState), 32'd5);
      run(3);
      check("err_held", 32'(bus.seqState), 32'd5);
      drive('0, '0, 2'b01);
      run(2);
      check("err_down_seq", 32'(bus.seqState), 32'd4);
      check("err_down_noerr", 32'(bus.pllErr), 32'd0);
      run(1);
      check("err_to_idle", 32'(bus.seqState), 32'd0);

      // Abort during ramp-up.
      drive(2'b10, 2'b00, 2'b10);
      run(2);
      check("abort_in_ramp", 32'(bus.seqState), 32'd1);
      drive('0, '0, 2'b10);
      run(1);
      check("abort_down", 32'(bus.seqState), 32'd4);
      run(2);
      check("abort_idle", 32'(bus.seqState), 32'd0);

      // Request drop coinciding with the PLL timeout edge.
      drive(2'b11, 2'b00, 2'b01);
      run(20);
      drive('0, '0, 2'b01);
      run(1);
      check("simul_down", 32'(bus.seqState), 32'd4);
      check("simul_noerr", 32'(bus.pllErr), 32'd0);
      run(2);

      // Isolation clamp while ACTIVE in RX mode.
      drive(2'b11, 2'b11, 2'b11);
      run(6);
      check("iso_pre_rx", 32'(bus.rxEn), 32'h3);
      bus.isolateM3 = 1'b1;
      #1;
      check("iso_rx_clamped", 32'(bus.rxEn), 32'd0);
      check("iso_seq_kept", 32'(bus.seqState), 32'd3);
      run(3);
      bus.isolateM3 = 1'b0;
      #1;
      check("iso_release_rx", 32'(bus.rxEn), 32'h3);

      // Asynchronous reset mid-ACTIVE, then restart.
      async_reset_pulse();
      check("arst_seq", 32'(bus.seqState), 32'd0);
      check("arst_rx", 32'(bus.rxEn), 32'd0);
      run(1);
      check("arst_restart", 32'(bus.seqState), 32'd1);
      drive('0, '0, '0);
      run(3);

      // Randomized episodes against the model.
      for (int ep = 0; ep < 60; ep++) begin
         en     = W'($urandom_range(1, 3));
         rx     = W'($urandom);
         mode   = $urandom_range(0, 3);
         target = (mode == 2) ? W'($urandom) : en;
         settle_at = (mode == 3) ? $urandom_range(0, 20) : 0;
         hold   = $urandom_range(1, 32);
         for (int c = 0; c < hold; c++) begin
            pll = (c >= settle_at) ? target : '0;
            if ($urandom_range(0, 15) == 0) pll = pll ^ W'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) en = W'($urandom_range(1, 3));
            if ($urandom_range(0, 11) == 0) bus.isolateM3 = ~bus.isolateM3;
            drive(en, rx, pll);
            cycle();
            if ($urandom_range(0, 199) == 0) async_reset_pulse();
         end
         gap = $urandom_range(1, 6);
         for (int c = 0; c < gap; c++) begin
            if ($urandom_range(0, 4) == 0) drive(W'($urandom_range(1, 3)), rx, pll);
            else drive('0, rx, pll);
            cycle();
         end
         drive('0, '0, '0);
         bus.isolateM3 = 1'b0;
         run(DOWN + 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/radio_ramp_sequencer.md
Name: radio_ramp_sequencer

Overview:
- Timing-engine stage directly downstream of stage 2 (m2). Consumes its per-channel radioEnable/radioRxEn vectors and the PLL-settled status.
- Sequences radio power-up: ramp, wait for PLL lock with timeout, active, ramp-down. Drives the final per-channel TX/RX enables with an isolation clamp.

Parameters:
BIT_WIDTH, 2, number of radio channels (matches timing-engine vector width)
RAMP_CYCLES, 4, ramp-up duration in ck cycles (>=1)
PLL_TIMEOUT, 16, max cycles in WAIT_PLL before error (>=1)
DOWN_CYCLES, 2, ramp-down duration in ck cycles (>=1)

Ports:
ck  input  1  clock
arst  input  1  asynchronous reset, active-high
isolateM3  input  1  isolation: clamp all outputs to 0 while high
radioEnable  input  BIT_WIDTH  per-channel enable request from stage 2
radioRxEn  input  BIT_WIDTH  per-channel RX(1)/TX(0) select from stage 2
pllSettled  input  BIT_WIDTH  per-channel PLL lock status
txEn  output  BIT_WIDTH  per-channel TX enable
rxEn  output  BIT_WIDTH  per-channel RX enable
rampActive  output  1  high in RAMP_UP or RAMP_DOWN
pllErr  output  1  high in ERROR state
seqState  output  3  encoded FSM state (debug)

Behaviour:
- One clock ck. Reset is asynchronous and active-high (arst); all flops clear immediately on arst rise.
- Reset values: state IDLE, counter 0, latched masks 0, txEn/rxEn/rampActive/pllErr 0, seqState 0.
- req = |radioEnable (combinational). chMask/rxMask are latched registers.
- States and encodings: IDLE=0, RAMP_UP=1, WAIT_PLL=2, ACTIVE=3, RAMP_DOWN=4, ERROR=5. All outputs are registered, derived from next state, so each output matches state in the same cycle.
- IDLE:
  - On req=1: latch chMask=radioEnable, rxMask=radioRxEn, cnt=0, go to RAMP_UP.
- RAMP_UP:
  - cnt increments each cycle.
  - At cnt==RAMP_CYCLES-1: go to WAIT_PLL with cnt=0. RAMP_UP lasts exactly RAMP_CYCLES cycles.
- WAIT_PLL:
  - If (pllSettled & chMask)==chMask: go to ACTIVE.
  - Else if cnt==PLL_TIMEOUT-1: go to ERROR.
  - Else cnt++.
- ACTIVE:
  - txEn = chMask & ~rxMask; rxEn = chMask & rxMask.
  - If any masked pllSettled bit drops: go to ERROR.
  - Changes to radioEnable/radioRxEn while ACTIVE are ignored unless req falls to 0.
- ERROR:
  - pllErr=1, txEn/rxEn=0.
  - Held until req=0, then go to RAMP_DOWN.
- RAMP_DOWN:
  - txEn/rxEn=0; lasts exactly DOWN_CYCLES cycles, then go to IDLE.
  - req reasserting during RAMP_DOWN is not sampled until IDLE.
- Priority:
  - req=0 in RAMP_UP, WAIT_PLL or ACTIVE: go to RAMP_DOWN (cnt=0).
  - This takes priority over PLL timeout, PLL loss and ramp completion occurring in the same cycle.
- rampActive = 1 in RAMP_UP and RAMP_DOWN only.
- isolateM3=1 forces txEn, rxEn, rampActive and pllErr to 0 at the output (combinational AND after the registers). FSM, counters and seqState continue unaffected. Deasserting isolation exposes current register values immediately.
- Counter width is $clog2(max(RAMP_CYCLES, PLL_TIMEOUT, DOWN_CYCLES)+1). The counter never wraps: it is reset on every state entry.
- arst asserted mid-sequence: immediate return to reset values. No ramp-down is performed.

Test Plan:
- Normal TX: radioEnable=2'b01, radioRxEn=0, pllSettled=2'b01 held -> rampActive high 4 cycles; txEn=2'b01 from the 6th cycle after req (1 IDLE-exit + 4 ramp + 1 pll check); rxEn=0.
- PLL timeout: radioEnable=2'b11, pllSettled=2'b01 -> after 4 ramp + 16 wait cycles pllErr=1, seqState=5. Drop radioEnable -> 2 cycles RAMP_DOWN, then IDLE with pllErr=0.
- Abort during ramp: radioEnable=2'b10 for 2 cycles, then 0 -> seqState 1 to 4, txEn/rxEn never asserted, IDLE after 2 cycles.
- Simultaneous events: req drops on the same cycle as the WAIT_PLL timeout -> RAMP_DOWN entered, pllErr never asserted.
- Isolation: reach ACTIVE with rxEn=2'b11, assert isolateM3 -> rxEn=0 in the same cycle, seqState stays 3. Release -> rxEn=2'b11 again.
- Reset mid-ACTIVE: pulse arst asynchronously between clock edges -> all outputs 0 immediately, seqState=0. A new request then restarts from RAMP_UP.
